pong_sequencer: RTL and testbench
=================================

Name: pong_sequencer

Overview:
- Top-level game controller that sequences the sprite widgets on the 800x600 VGA display.
- Derives a once-per-frame tick from the scan position.
- Gates the widgets' movement with a one-cycle enable pulse, re-serves the ball through a one-cycle widget reset, and detects scoring from ball position.
- Keeps two saturating scores and a serve/play/game-over state machine.

Parameters:
- FRAME_X, 799, scan X at which the frame tick fires
- FRAME_Y, 599, scan Y at which the frame tick fires
- SPEED_DIV, 2, frame ticks per widget enable pulse (1..15)
- SERVE_FRAMES, 60, frame ticks the ball is held in SERVE before play
- LEFT_LIMIT, 0, ballX at or below this scores for the right player
- RIGHT_LIMIT, 799, ballX+ballXSize at or above this scores for the left player
- WIN_SCORE, 9, score that ends the game (1..15)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- X  in  11  current scan column
- Y  in  11  current scan row
- ballX  in  11  ball widget left edge, unsigned
- ballXSize  in  9  ball widget width
- start  in  1  start button, already synchronised and debounced
- widgetEnable  out  1  one-cycle movement pulse to all widgets
- widgetReset  out  1  one-cycle pulse that reloads widget start positions
- scoreLeft  out  4  left player score
- scoreRight  out  4  right player score
- state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
- gameOver  out  1  high while state==OVER

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; frame, divider and serve counters 0.
  - startPrev=1, so a start button held through reset does not fire.
- frameTick: combinational, (X==FRAME_X)&&(Y==FRAME_Y); true one cycle per frame.
- startEdge: start && !startPrev; startPrev is registered every cycle.
- IDLE:
  - On startEdge, go to SERVE, clear both scores, and pulse widgetReset on the next cycle.
- SERVE:
  - Count frameTicks.
  - When SERVE_FRAMES ticks have elapsed, go to PLAY and clear the divider.
  - widgetEnable stays 0.
- PLAY:
  - Divider increments on each frameTick. When it reaches SPEED_DIV-1 and frameTick is high, pulse widgetEnable for that same cycle (registered, so the output appears one cycle after the tick) and wrap the divider to 0.
  - Score check runs only on frameTick cycles, using a 12-bit sum ballX+ballXSize (no wrap).
  - Both limits hit in the same tick: left-edge check wins (right player scores).
  - On a score: increment the winner's score, pulse widgetReset, and go to SERVE (serve counter cleared). If the new score equals WIN_SCORE, go to OVER instead; widgetReset is still pulsed.
  - Scores saturate at 15.
- OVER:
  - Scores held. On startEdge, clear scores, pulse widgetReset, and go to SERVE.
- widgetReset and widgetEnable are never high in the same cycle.
- startEdge in SERVE or PLAY is ignored.
- reset mid-game: returns to IDLE on the next edge and clears everything; no widgetReset pulse is issued (the widgets share the system reset).

Optional Feature:
- PONG_PAUSE_EN
  - Defined: adds input pause (1 bit). While pause=1 in PLAY, the divider and score checks freeze and widgetEnable is suppressed. Releasing pause resumes with the divider value intact. pause has no effect in other states.
  - Undefined: the port is absent and behaviour is as above.

Decomposition:
- Package pong_pkg: state encoding constants (IDLE/SERVE/PLAY/OVER), screen constants 799/599, score width 4.
- Sub-module frame_tick_gen: X,Y compare, plus the SPEED_DIV divider producing the raw tick and the move strobe. It is reused by future sprite controllers.
- The state machine, scoring and start-edge logic stay in pong_sequencer.

Test Plan:
- Reset, then start pulse, then SERVE with 60 frame ticks -> widgetReset high exactly 1 cycle after the edge; state==PLAY one cycle after the 60th tick; widgetEnable 0 throughout SERVE.
- PLAY, SPEED_DIV=2, ballX=400, 10 frames -> exactly 5 widgetEnable pulses, each 1 cycle wide, one cycle after alternate ticks; scores unchanged.
- PLAY, ballX=0 at frameTick -> scoreRight 0->1, widgetReset pulse, state==SERVE. Then ballX=790, ballXSize=9 -> scoreLeft 0->1.
- scoreLeft=8, ballX=795, ballXSize=10 at tick -> scoreLeft=9, state==OVER, gameOver=1. Start held during reset: no action. Then a clean start edge -> scores 0, state==SERVE.
- ballX=0 with ballXSize=900 (both limits) -> only scoreRight increments. Ball at the limit on a non-tick cycle -> no score.
- PONG_PAUSE_EN build: pause=1 for 5 frames in PLAY -> no widgetEnable, divider held. Release -> the next pulse follows the pre-pause phase.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong game controller.
//   - ST_* : sequencer state encoding (IDLE/SERVE/PLAY/OVER), visible on the
//            state output so checkers can bind to it directly.
//   - SCREEN_X_MAX / SCREEN_Y_MAX : last visible scan column/row on 800x600.
//   - COORD_W / SCORE_W : coordinate and score widths.
//   - sat_inc : saturating score increment.
package pong_pkg;

  localparam int COORD_W      = 11;
  localparam int SCORE_W      = 4;
  localparam int SCREEN_X_MAX = 799;
  localparam int SCREEN_Y_MAX = 599;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // Scores stop at all-ones instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/pong_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings.
//   master : scan position, ball geometry and start button in; pulses,
//            scores, state and gameOver observed.
//   slave  : the sequencer side.
// Optional macro PONG_PAUSE_EN adds the pause input.
//
// Signalling: there is no valid/ready pair. X/Y/ballX/ballXSize/start are
// sampled every clock. widgetEnable and widgetReset are single-cycle,
// registered pulses that are never high together; consumers act on any
// cycle in which they are high and need not acknowledge them.
interface pong_sequencer_if;
  import pong_pkg::*;

  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic [COORD_W-1:0] ballX;
  logic [8:0]         ballXSize;
  logic               start;
`ifdef PONG_PAUSE_EN
  logic               pause;
`endif
  logic               widgetEnable;
  logic               widgetReset;
  logic [SCORE_W-1:0] scoreLeft;
  logic [SCORE_W-1:0] scoreRight;
  logic [1:0]         state;
  logic               gameOver;

  modport master (
    output X, Y, ballX, ballXSize, start,
`ifdef PONG_PAUSE_EN
    output pause,
`endif
    input  widgetEnable, widgetReset, scoreLeft, scoreRight, state, gameOver
  );

  modport slave (
    input  X, Y, ballX, ballXSize, start,
`ifdef PONG_PAUSE_EN
    input  pause,
`endif
    output widgetEnable, widgetReset, scoreLeft, scoreRight, state, gameOver
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick and movement strobe generator.
//   clk, reset : pixel clock, synchronous active-high reset
//   x, y       : current scan position
//   run        : divider advances on ticks only while high
//   clear      : synchronous divider clear (takes priority over run)
//   tick       : combinational, high while (x,y) == (FRAME_X,FRAME_Y)
//   move       : combinational, high on the tick that completes SPEED_DIV
//                running ticks
module frame_tick_gen
  import pong_pkg::*;
#(
  parameter int FRAME_X   = SCREEN_X_MAX,
  parameter int FRAME_Y   = SCREEN_Y_MAX,
  parameter int SPEED_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               run,
  input  logic               clear,
  output logic               tick,
  output logic               move
);

  localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);

  logic [3:0] div_cnt;

  assign tick = (x == COORD_W'(FRAME_X)) && (y == COORD_W'(FRAME_Y));
  assign move = tick && run && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= 4'd0;
    end else if (tick && run) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/pong_sequencer.sv
// Pong game sequencer: serve/play/game-over control, scoring and widget
// movement gating for the 800x600 display.
//   clk, reset : pixel clock, synchronous active-high reset
//   bus        : pong_sequencer_if.slave (scan position, ball geometry,
//                start button; widgetEnable/widgetReset pulses, scores,
//                state, gameOver)
// Optional macro PONG_PAUSE_EN: adds bus.pause, which freezes the divider
// and score checks in PLAY and suppresses widgetEnable.
module pong_sequencer
  import pong_pkg::*;
#(
  parameter int FRAME_X      = SCREEN_X_MAX,
  parameter int FRAME_Y      = SCREEN_Y_MAX,
  parameter int SPEED_DIV    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 799,
  parameter int WIN_SCORE    = 9
) (
  input  logic             clk,
  input  logic             reset,
  pong_sequencer_if.slave  bus
);

  localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  logic [1:0]         st;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               w_en;
  logic               w_rst;
  logic [15:0]        serve_cnt;
  logic               startPrev;

  logic               startEdge;
  logic               paused;
  logic               run;
  logic               frame_tick;
  logic               move;
  logic               div_clear;
  logic               score_tick;
  logic [11:0]        ball_right;
  logic               hit_left;
  logic               hit_right;
  logic [SCORE_W-1:0] score_l_inc;
  logic [SCORE_W-1:0] score_r_inc;

`ifdef PONG_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign startEdge  = bus.start && !startPrev;
  assign run        = (st == ST_PLAY) && !paused;
  // Divider restarts its phase every time play resumes after a serve.
  assign div_clear  = (st == ST_SERVE) && frame_tick && (serve_cnt == SERVE_LAST);
  assign score_tick = frame_tick && run;

  // 12-bit sum so a ball near the right edge cannot wrap to a small value.
  assign ball_right = {1'b0, bus.ballX} + {3'b000, bus.ballXSize};
  assign hit_left   = bus.ballX <= COORD_W'(LEFT_LIMIT);
  assign hit_right  = ball_right >= 12'(RIGHT_LIMIT);

  assign score_l_inc = sat_inc(score_l);
  assign score_r_inc = sat_inc(score_r);

  frame_tick_gen #(
    .FRAME_X   (FRAME_X),
    .FRAME_Y   (FRAME_Y),
    .SPEED_DIV (SPEED_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .x     (bus.X),
    .y     (bus.Y),
    .run   (run),
    .clear (div_clear),
    .tick  (frame_tick),
    .move  (move)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      score_l   <= '0;
      score_r   <= '0;
      w_en      <= 1'b0;
      w_rst     <= 1'b0;
      serve_cnt <= 16'd0;
      // A button held through reset must not look like a fresh press.
      startPrev <= 1'b1;
    end else begin
      startPrev <= bus.start;
      w_en      <= 1'b0;
      w_rst     <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (startEdge) begin
            st        <= ST_SERVE;
            score_l   <= '0;
            score_r   <= '0;
            w_rst     <= 1'b1;
            serve_cnt <= 16'd0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              st        <= ST_PLAY;
              serve_cnt <= 16'd0;
            end else begin
              serve_cnt <= serve_cnt + 16'd1;
            end
          end
        end
        ST_PLAY: begin
          // Left-edge check first: a ball spanning both limits scores right.
          // A scoring tick suppresses the move pulse so the reset pulse
          // never coincides with it.
          if (score_tick && hit_left) begin
            score_r   <= score_r_inc;
            w_rst     <= 1'b1;
            serve_cnt <= 16'd0;
            st        <= (score_r_inc == WIN) ? ST_OVER : ST_SERVE;
          end else if (score_tick && hit_right) begin
            score_l   <= score_l_inc;
            w_rst     <= 1'b1;
            serve_cnt <= 16'd0;
            st        <= (score_l_inc == WIN) ? ST_OVER : ST_SERVE;
          end else begin
            w_en <= move;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.widgetEnable = w_en;
  assign bus.widgetReset  = w_rst;
  assign bus.scoreLeft    = score_l;
  assign bus.scoreRight   = score_r;
  assign bus.state        = st;
  assign bus.gameOver     = (st == ST_OVER);

endmodule

// File: tb/tb_pong_sequencer.sv
// Directed bench for pong_sequencer with default parameters.
// Frame ticks are produced by parking X/Y on (799,599) for one cycle.
module tb_pong_sequencer;
  import pong_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_sequencer_if bus();

  pong_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int en_cycles = 0;
  int wr_cycles = 0;
  int overlap   = 0;
  logic [31:0] exp_q[$];

  // Pulse monitor: counts high cycles and any enable/reset overlap.
  always @(negedge clk) begin
    if (bus.widgetEnable === 1'b1) en_cycles++;
    if (bus.widgetReset === 1'b1) wr_cycles++;
    if (bus.widgetEnable === 1'b1 && bus.widgetReset === 1'b1) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: one tick cycle, sample the registered response,
  // then one idle cycle. Returns at a negedge.
  task automatic do_tick(output logic en, output logic wr);
    bus.X = 11'd799;
    bus.Y = 11'd599;
    @(negedge clk);
    en = bus.widgetEnable;
    wr = bus.widgetReset;
    bus.X = 11'd100;
    bus.Y = 11'd100;
    @(negedge clk);
  endtask

  task automatic serve_phase();
    logic e, w;
    repeat (60) do_tick(e, w);
  endtask

  task automatic set_ball(input logic [10:0] x, input logic [8:0] sz);
    bus.ballX     = x;
    bus.ballXSize = sz;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic e, w, pe;
    int base;

    reset     = 1'b1;
    bus.start = 1'b1;
    bus.X     = 11'd100;
    bus.Y     = 11'd100;
    set_ball(11'd400, 9'd16);
`ifdef PONG_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_state", bus.state, ST_IDLE);
    check("rst_score_l", bus.scoreLeft, 0);
    check("rst_score_r", bus.scoreRight, 0);
    check("rst_en", bus.widgetEnable, 0);
    check("rst_wr", bus.widgetReset, 0);
    check("rst_over", bus.gameOver, 0);

    // start held through reset must not start the game
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_state", bus.state, ST_IDLE);
    check("held_start_wr", bus.widgetReset, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // clean start edge
    bus.start = 1'b1;
    @(negedge clk);
    check("start_wr", bus.widgetReset, 1);
    check("start_state", bus.state, ST_SERVE);
    bus.start = 1'b0;
    @(negedge clk);
    check("start_wr_width", bus.widgetReset, 0);

    // serve: 59 ticks stay in SERVE, 60th enters PLAY
    base = en_cycles;
    repeat (59) do_tick(e, w);
    check("serve_59", bus.state, ST_SERVE);
    do_tick(e, w);
    check("serve_to_play", bus.state, ST_PLAY);
    check("serve_no_en", en_cycles - base, 0);

    // 10 frames, SPEED_DIV=2: pulse follows ticks 2,4,6,8,10
    base = en_cycles;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(32'(i % 2));
      do_tick(e, w);
      check($sformatf("en_phase_%0d", i), {31'd0, e}, exp_q.pop_front());
    end
    check("en_count_10", en_cycles - base, 5);
    check("play_score_l", bus.scoreLeft, 0);
    check("play_score_r", bus.scoreRight, 0);

    // ball at left limit on non-tick cycles: no score
    set_ball(11'd0, 9'd16);
    repeat (3) @(negedge clk);
    check("nontick_score_r", bus.scoreRight, 0);
    check("nontick_state", bus.state, ST_PLAY);
    do_tick(e, w);
    check("left_hit_wr", {31'd0, w}, 1);
    check("left_hit_score_r", bus.scoreRight, 1);
    check("left_hit_state", bus.state, ST_SERVE);

    // right limit: 790 + 9 = 799
    set_ball(11'd400, 9'd16);
    serve_phase();
    set_ball(11'd790, 9'd9);
    do_tick(e, w);
    check("right_hit_wr", {31'd0, w}, 1);
    check("right_hit_score_l", bus.scoreLeft, 1);
    check("right_hit_state", bus.state, ST_SERVE);

    // bring scoreLeft to 8
    for (int i = 0; i < 7; i++) begin
      set_ball(11'd400, 9'd16);
      serve_phase();
      set_ball(11'd790, 9'd9);
      do_tick(e, w);
    end
    check("score_l_8", bus.scoreLeft, 8);
    check("score_l_8_state", bus.state, ST_SERVE);

    // winning point: 795 + 10 = 805
    set_ball(11'd400, 9'd16);
    serve_phase();
    set_ball(11'd795, 9'd10);
    do_tick(e, w);
    check("win_wr", {31'd0, w}, 1);
    check("win_score_l", bus.scoreLeft, 9);
    check("win_state", bus.state, ST_OVER);
    check("win_game_over", bus.gameOver, 1);

    // OVER holds scores even with the ball at a limit
    set_ball(11'd0, 9'd16);
    do_tick(e, w);
    check("over_hold_r", bus.scoreRight, 1);
    check("over_hold_state", bus.state, ST_OVER);

    // restart from OVER
    bus.start = 1'b1;
    @(negedge clk);
    check("restart_state", bus.state, ST_SERVE);
    check("restart_score_l", bus.scoreLeft, 0);
    check("restart_score_r", bus.scoreRight, 0);
    check("restart_wr", bus.widgetReset, 1);
    check("restart_game_over", bus.gameOver, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // start edge in PLAY is ignored
    set_ball(11'd400, 9'd16);
    serve_phase();
    bus.start = 1'b1;
    @(negedge clk);
    check("play_start_state", bus.state, ST_PLAY);
    check("play_start_wr", bus.widgetReset, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // both limits at once: right player scores only
    set_ball(11'd0, 9'd900);
    repeat (3) @(negedge clk);
    check("both_nontick_r", bus.scoreRight, 0);
    do_tick(e, w);
    check("both_score_r", bus.scoreRight, 1);
    check("both_score_l", bus.scoreLeft, 0);

    // pulse totals: 1 start + 1 + 8 + 1 scores + 1 restart + 1 both
    check("wr_total", wr_cycles, 13);
    check("en_total", en_cycles, 5);
    check("no_overlap", overlap, 0);

    set_ball(11'd400, 9'd16);
    serve_phase();
`ifdef PONG_PAUSE_EN
    do_tick(e, w);
    check("pre_pause_en", {31'd0, e}, 0);
    bus.pause = 1'b1;
    pe = 1'b0;
    repeat (5) begin
      do_tick(e, w);
      pe = pe | e;
    end
    check("pause_no_en", {31'd0, pe}, 0);
    bus.pause = 1'b0;
    do_tick(e, w);
    check("resume_phase_en", {31'd0, e}, 1);
    pe = 1'b0;
`else
    pe = 1'b0;
`endif
    check("mid_state_play", bus.state, ST_PLAY);

    // reset mid-game
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", bus.state, ST_IDLE);
    check("midrst_score_r", bus.scoreRight, 0);
    check("midrst_wr", bus.widgetReset, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle_hold", bus.state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
